// File: rtl/sg_mac_sequencer.sv
// sg_mac_sequencer: time-multiplexed Savitzky-Golay MAC controller.
//
// Incoming samples go into a circular window of WINDOW_SIZE entries. Once the
// window is full, every accepted sample starts a pass over all taps. One
// shared multiplier does one tap per cycle. Tap 0 uses the newest sample. The
// pass result is shifted right by SHIFT and driven on a valid/ready output.
//
// Optional build macro: SG_SATURATE_EN. When it is defined, the shifted
// accumulator is clamped to the DATA_W signed range. When it is not defined,
// the low DATA_W bits are used and the value wraps. Latency is the same in
// both builds.
//
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   in_valid/in_ready     sample input handshake; in_data is the signed sample
//   out_valid/out_ready   result output handshake; out_data is the signed result
//   coef_wr/addr/data     runtime coefficient write; accepted only in idle without flush
//   flush                 synchronous window clear; drops any in-flight result
//   busy                  high while a pass is running or a result is pending
`timescale 1ns/1ps

module sg_mac_sequencer #(
    parameter int unsigned WINDOW_SIZE = 55,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned SHIFT       = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic signed [DATA_W-1:0]          in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic signed [DATA_W-1:0]          out_data,
    input  logic                              coef_wr,
    input  logic [$clog2(WINDOW_SIZE)-1:0]    coef_addr,
    input  logic signed [DATA_W-1:0]          coef_data,
    input  logic                              flush,
    output logic                              busy
);

    localparam int unsigned AW     = $clog2(WINDOW_SIZE);
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned ACC_W  = PROD_W + AW;

    localparam logic [AW-1:0] LAST = AW'(WINDOW_SIZE - 1);
    localparam logic [AW:0]   FULL = (AW + 1)'(WINDOW_SIZE);

    typedef enum logic [1:0] {StIdle, StMac, StOut} state_t;

    state_t                    state_q;
    logic [AW-1:0]             wr_ptr_q;
    logic [AW:0]               fill_cnt_q;
    logic [AW-1:0]             tap_q;
    logic [AW-1:0]             rd_ptr_q;
    logic                      issue_q;
    logic                      prod_vld_q;
    logic signed [PROD_W-1:0]  prod_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic                      rdy_q;
    logic                      out_valid_q;
    logic signed [DATA_W-1:0]  out_data_q;

    logic signed [DATA_W-1:0]  sample_mem [WINDOW_SIZE];
    logic signed [DATA_W-1:0]  coef_mem   [WINDOW_SIZE];

    logic                      accept;
    logic                      coef_we;
    logic [AW:0]               fill_cnt_inc;
    logic signed [DATA_W-1:0]  coef_rd;
    logic signed [DATA_W-1:0]  smp_rd;
    logic signed [PROD_W-1:0]  mult;
    logic signed [ACC_W-1:0]   acc_sum;
    logic signed [ACC_W-1:0]   shifted;
    logic signed [DATA_W-1:0]  result;

    // rdy_q stays low for the first cycle after reset so that in_ready is low during reset.
    assign in_ready  = rdy_q && !flush;
    assign accept    = in_valid && in_ready;
    assign coef_we   = coef_wr && (state_q == StIdle) && !flush && (coef_addr <= LAST);
    assign busy      = (state_q == StMac) || (state_q == StOut);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    assign fill_cnt_inc = (fill_cnt_q == FULL) ? FULL : fill_cnt_q + 1'b1;

    // The storage arrays have no reset. Their contents survive reset and flush.
    always_ff @(posedge clk) begin
        if (accept) begin
            sample_mem[wr_ptr_q] <= in_data;
        end
        if (coef_we) begin
            coef_mem[coef_addr] <= coef_data;
        end
    end

    assign coef_rd = coef_mem[tap_q];
    assign smp_rd  = sample_mem[rd_ptr_q];

    // Both operands are sign-extended to the full product width. The product always fits in that width.
    assign mult = $signed({{DATA_W{coef_rd[DATA_W-1]}}, coef_rd})
                * $signed({{DATA_W{smp_rd[DATA_W-1]}}, smp_rd});

    // The final product is still held in prod_q, so the output path adds it in here.
    assign acc_sum = acc_q + $signed({{AW{prod_q[PROD_W-1]}}, prod_q});
    assign shifted = acc_sum >>> SHIFT;

`ifdef SG_SATURATE_EN
    logic [ACC_W-DATA_W:0] shifted_hi;
    assign shifted_hi = shifted[ACC_W-1:DATA_W-1];
    always_comb begin
        result = shifted[DATA_W-1:0];
        // The value fits only if every bit above the kept sign bit matches it.
        if (!(&shifted_hi) && (|shifted_hi)) begin
            result = shifted[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                      : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end
`else
    logic unused_shifted_hi;
    assign unused_shifted_hi = ^shifted[ACC_W-1:DATA_W];
    assign result            = shifted[DATA_W-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            fill_cnt_q  <= '0;
            tap_q       <= '0;
            rd_ptr_q    <= '0;
            issue_q     <= 1'b0;
            prod_vld_q  <= 1'b0;
            prod_q      <= '0;
            acc_q       <= '0;
            rdy_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (flush) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            fill_cnt_q  <= '0;
            issue_q     <= 1'b0;
            prod_vld_q  <= 1'b0;
            acc_q       <= '0;
            rdy_q       <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    rdy_q <= 1'b1;
                    if (accept) begin
                        wr_ptr_q   <= (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
                        fill_cnt_q <= fill_cnt_inc;
                        if (fill_cnt_inc == FULL) begin
                            state_q    <= StMac;
                            rdy_q      <= 1'b0;
                            acc_q      <= '0;
                            tap_q      <= '0;
                            rd_ptr_q   <= wr_ptr_q;  // slot that was just written
                            issue_q    <= 1'b1;
                            prod_vld_q <= 1'b0;
                        end
                    end
                end
                StMac: begin
                    // The product is registered, so accumulation runs one cycle behind tap issue.
                    prod_q     <= mult;
                    prod_vld_q <= issue_q;
                    if (prod_vld_q) begin
                        acc_q <= acc_sum;
                    end
                    if (issue_q) begin
                        rd_ptr_q <= (rd_ptr_q == '0) ? LAST : rd_ptr_q - 1'b1;
                        if (tap_q == LAST) begin
                            issue_q <= 1'b0;
                        end else begin
                            tap_q <= tap_q + 1'b1;
                        end
                    end else begin
                        state_q     <= StOut;
                        out_valid_q <= 1'b1;
                        out_data_q  <= result;
                    end
                end
                StOut: begin
                    if (out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        rdy_q       <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sg_mac_sequencer.sv
// Directed bench for sg_mac_sequencer with a 5-tap window and no output shift.
`timescale 1ns/1ps

module tb_sg_mac_sequencer;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_data;
    logic               coef_wr;
    logic [2:0]         coef_addr;
    logic signed [15:0] coef_data;
    logic               flush;
    logic               busy;

    int checks = 0;
    int errors = 0;

    sg_mac_sequencer #(
        .WINDOW_SIZE (5),
        .DATA_W      (16),
        .SHIFT       (0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .coef_wr   (coef_wr),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .flush     (flush),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] v);
        in_valid = 1'b1;
        in_data  = v;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic write_coef(input logic [2:0] a, input logic [15:0] d);
        coef_wr   = 1'b1;
        coef_addr = a;
        coef_data = d;
        tick();
        coef_wr = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic load_ramp_coefs();
        for (int i = 0; i < 5; i++) write_coef(3'(i), 16'(i + 1));
    endtask

    // Returns the number of cycles until out_valid rises, or -1 if the bound expires.
    task automatic wait_out(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (out_valid === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic take_output();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 16'sd0) begin
            errors++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b out_data=%0d, want 0 0 0 0",
                     in_ready, out_valid, busy, out_data);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle_ready: in_ready=%b want 1", in_ready);
        end
    endtask

    task automatic test_fill_first_output();
        int n;
        load_ramp_coefs();
        for (int i = 1; i <= 4; i++) send(16'(i));
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL fill_partial: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
        send(16'd5);
        wait_out(n);
        checks++;
        if (n != 6) begin
            errors++;
            $display("FAIL first_latency: got %0d cycles want 6", n);
        end
        checks++;
        if (out_data !== 16'sd35 || busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL first_result: out_data=%0d busy=%b in_ready=%b want 35 1 0",
                     out_data, busy, in_ready);
        end
        take_output();
        send(16'd6);
        wait_out(n);
        checks++;
        if (n != 6 || out_data !== 16'sd50) begin
            errors++;
            $display("FAIL second_result: out_data=%0d latency=%0d want 50 6", out_data, n);
        end
        take_output();
    endtask

    task automatic test_partial_flush();
        int n;
        do_flush();
        for (int i = 1; i <= 4; i++) begin
            send(16'(i * 7));
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL partial_fill_%0d: out_valid=%b in_ready=%b want 0 1",
                         i, out_valid, in_ready);
            end
        end
        // A sample offered together with flush must be dropped.
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'd99;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready: in_ready=%b want 0", in_ready);
        end
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        for (int i = 1; i <= 4; i++) send(16'(i * 10));
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL after_flush_no_output: out_valid=%b busy=%b want 0 0", out_valid, busy);
        end
        send(16'd50);
        wait_out(n);
        checks++;
        if (n < 0 || out_data !== 16'sd350) begin
            errors++;
            $display("FAIL after_flush_result: out_data=%0d latency=%0d want 350", out_data, n);
        end
        take_output();
    endtask

    task automatic test_backpressure();
        int n;
        int bad;
        do_flush();
        for (int i = 1; i <= 5; i++) send(16'(i));
        wait_out(n);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid !== 1'b1 || out_data !== 16'sd35 || in_ready !== 1'b0 || busy !== 1'b1)
                bad++;
        end
        checks++;
        if (n < 0 || bad != 0) begin
            errors++;
            $display("FAIL backpressure_hold: bad_cycles=%0d latency=%0d out_data=%0d want 0 35",
                     bad, n, out_data);
        end
        take_output();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release: out_valid=%b in_ready=%b busy=%b want 0 1 0",
                     out_valid, in_ready, busy);
        end
    endtask

    task automatic test_overflow();
        int n;
        logic [15:0] exp_v;
`ifdef SG_SATURATE_EN
        exp_v = 16'd32767;
`else
        exp_v = 16'd5;
`endif
        do_flush();
        for (int i = 0; i < 5; i++) write_coef(3'(i), 16'd32767);
        for (int i = 0; i < 5; i++) send(16'd32767);
        wait_out(n);
        checks++;
        if (n < 0 || out_data !== exp_v) begin
            errors++;
            $display("FAIL overflow: out_data=%0d want %0d", out_data, exp_v);
        end
        take_output();
        load_ramp_coefs();
    endtask

    task automatic test_coef_write_gating();
        int n;
        do_flush();
        for (int i = 1; i <= 5; i++) send(16'(i));
        tick();
        write_coef(3'd0, 16'd100);
        wait_out(n);
        checks++;
        if (n < 0 || out_data !== 16'sd35) begin
            errors++;
            $display("FAIL coef_write_in_mac: out_data=%0d want 35", out_data);
        end
        // A write while OUT is pending must also be ignored.
        write_coef(3'd0, 16'd100);
        take_output();
        do_flush();
        for (int i = 1; i <= 5; i++) send(16'(i));
        wait_out(n);
        checks++;
        if (n < 0 || out_data !== 16'sd35) begin
            errors++;
            $display("FAIL coef_write_in_out: out_data=%0d want 35", out_data);
        end
        take_output();
        write_coef(3'd0, 16'd100);
        do_flush();
        for (int i = 1; i <= 5; i++) send(16'(i));
        wait_out(n);
        checks++;
        if (n < 0 || out_data !== 16'sd530) begin
            errors++;
            $display("FAIL coef_write_in_idle: out_data=%0d want 530", out_data);
        end
        take_output();
        write_coef(3'd0, 16'd1);
    endtask

    task automatic test_reset_mid_mac();
        int n;
        int bad;
        do_flush();
        for (int i = 1; i <= 5; i++) send(16'(i));
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_mac: out_valid=%b busy=%b in_ready=%b want 0 0 0",
                     out_valid, busy, in_ready);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        bad = 0;
        for (int i = 1; i <= 4; i++) begin
            send(16'(i));
            if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_refill_no_output: bad_cycles=%0d want 0", bad);
        end
        send(16'd5);
        wait_out(n);
        checks++;
        if (n != 6 || out_data !== 16'sd35) begin
            errors++;
            $display("FAIL reset_fresh_window: out_data=%0d latency=%0d want 35 6", out_data, n);
        end
        take_output();
    endtask

    initial begin
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        coef_wr   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        flush     = 1'b0;
        rst_n     = 1'b1;
        #3;
        test_reset();
        test_fill_first_output();
        test_partial_flush();
        test_backpressure();
        test_overflow();
        test_coef_write_gating();
        test_reset_mid_mac();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
